// File: rtl/wino_pkg.sv
// Shared Winograd F(2x2,3x3) definitions: tile size, the B^T coefficient
// table and the per-stage datapath width rule. Also used by the filter and
// output transforms.
package wino_pkg;

  localparam int TILE = 4;

  // Rows of B^T; entry [i][j] weights input j in output i.
  localparam int BT [TILE][TILE] = '{
    '{1,  0, -1,  0},
    '{0,  1,  1,  0},
    '{0, -1,  1,  0},
    '{0,  1,  0, -1}
  };

  // Each 1-D pass adds one bit of growth over the activation width.
  function automatic int stage_width(input int wi, input int stage);
    return wi + stage;
  endfunction

endpackage

// File: rtl/wino_input_transform_if.sv
// Row-in / tile-out handshake bundle of the Winograd input transform.
// The master drives rows and out_ready; the slave is the transform itself.
interface wino_input_transform_if #(
  parameter int WI = 8,
  parameter int WO = 10
);
  import wino_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic                     in_first;
  logic [TILE*WI-1:0]       in_row;
  logic                     out_valid;
  logic                     out_ready;
  logic [TILE*TILE*WO-1:0]  out_v;
  logic                     err_resync;

  modport master (
    output in_valid, in_first, in_row, out_ready,
    input  in_ready, out_valid, out_v, err_resync
  );

  modport slave (
    input  in_valid, in_first, in_row, out_ready,
    output in_ready, out_valid, out_v, err_resync
  );

endinterface

// File: rtl/wino_bt_1d.sv
// Four-point combinational 1-D B^T transform. Inputs are sign-extended to the
// output width first, so a WOUT of WIN+1 is lossless.
module wino_bt_1d
  import wino_pkg::*;
#(
  parameter int WIN  = 8,
  parameter int WOUT = 9
) (
  input  logic signed [WIN-1:0]  x_i [TILE],
  output logic signed [WOUT-1:0] y_o [TILE]
);

  logic signed [WOUT-1:0] xe [TILE];

  for (genvar j = 0; j < TILE; j++) begin : g_ext
    assign xe[j] = {{(WOUT-WIN){x_i[j][WIN-1]}}, x_i[j]};
  end

  // Coefficients are only 0/+1/-1, so each output is a short add/sub chain.
  always_comb begin
    for (int i = 0; i < TILE; i++) begin
      y_o[i] = '0;
      for (int j = 0; j < TILE; j++) begin
        if (BT[i][j] == 1) begin
          y_o[i] = y_o[i] + xe[j];
        end else if (BT[i][j] == -1) begin
          y_o[i] = y_o[i] - xe[j];
        end
      end
    end
  end

endmodule

// File: rtl/wino_input_transform.sv
// Winograd input transform V = B^T*d*B on 4x4 tiles received one row per beat.
// Pipeline: row buffer -> column pass (T) -> row pass + width conversion (V).
// Optional macro WINO_IN_SAT_EN: clamp V elements instead of wrapping when
// WO is narrower than the lossless WI+2 bits.
module wino_input_transform
  import wino_pkg::*;
#(
  parameter int WI = 8,
  parameter int WO = 10
) (
  input  logic clk,
  input  logic rst,
  wino_input_transform_if.slave bus
);

  localparam int W1 = stage_width(WI, 1);
  localparam int W2 = stage_width(WI, 2);

  logic [1:0]             row_cnt_q, row_cnt_d, wr_idx;
  logic                   tile_full_q, tile_full_d;
  logic                   s1_valid_q, out_valid_q, err_q;
  logic signed [WI-1:0]   row_q [TILE][TILE];
  logic signed [W1-1:0]   t_q   [TILE][TILE];
  logic signed [WO-1:0]   v_q   [TILE][TILE];

  logic signed [WI-1:0]   col   [TILE][TILE];
  logic signed [W1-1:0]   tcol  [TILE][TILE];
  logic signed [W2-1:0]   vfull [TILE][TILE];
  logic signed [WO-1:0]   vconv [TILE][TILE];

  logic accept, resync, s1_load, s2_load;

  assign s2_load      = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign s1_load      = tile_full_q & (~s1_valid_q | s2_load);
  assign bus.in_ready = ~tile_full_q | s1_load;
  assign accept       = bus.in_valid & bus.in_ready;
  assign resync       = accept & bus.in_first & (row_cnt_q != 2'd0);
  assign wr_idx       = resync ? 2'd0 : row_cnt_q;

  assign bus.out_valid  = out_valid_q;
  assign bus.err_resync = err_q;

  for (genvar r = 0; r < TILE; r++) begin : g_outr
    for (genvar c = 0; c < TILE; c++) begin : g_outc
      assign bus.out_v[(TILE*r+c)*WO +: WO] = v_q[r][c];
    end
  end

  // Row counter and tile-full flag; a resync row restarts the tile as row 0.
  always_comb begin
    row_cnt_d   = row_cnt_q;
    tile_full_d = tile_full_q;
    if (s1_load) begin
      tile_full_d = 1'b0;
    end
    if (accept) begin
      if (resync) begin
        row_cnt_d = 2'd1;
      end else if (row_cnt_q == 2'd3) begin
        row_cnt_d   = 2'd0;
        tile_full_d = 1'b1;
      end else begin
        row_cnt_d = row_cnt_q + 2'd1;
      end
    end
  end

  // Present the buffered tile column by column to the first 1-D pass.
  always_comb begin
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        col[c][r] = row_q[r][c];
      end
    end
  end

  for (genvar g = 0; g < TILE; g++) begin : g_pass
    wino_bt_1d #(.WIN(WI), .WOUT(W1)) u_col (.x_i(col[g]), .y_o(tcol[g]));
    wino_bt_1d #(.WIN(W1), .WOUT(W2)) u_row (.x_i(t_q[g]), .y_o(vfull[g]));
  end

`ifdef WINO_IN_SAT_EN
  localparam logic signed [W2-1:0] SAT_HI = W2'((2 ** (WO - 1)) - 1);
  localparam logic signed [W2-1:0] SAT_LO = ~SAT_HI;
`endif

  // Narrow the lossless V to WO bits: clamp when enabled, else keep the LSBs.
  always_comb begin
    for (int r = 0; r < TILE; r++) begin
      for (int c = 0; c < TILE; c++) begin
        vconv[r][c] = WO'(vfull[r][c]);
`ifdef WINO_IN_SAT_EN
        if (WO < W2) begin
          if (vfull[r][c] > SAT_HI) begin
            vconv[r][c] = WO'(SAT_HI);
          end else if (vfull[r][c] < SAT_LO) begin
            vconv[r][c] = WO'(SAT_LO);
          end
        end
`endif
      end
    end
  end

  // Pipeline control registers; reset drops every in-flight row and tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt_q   <= 2'd0;
      tile_full_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      row_cnt_q   <= row_cnt_d;
      tile_full_q <= tile_full_d;
      err_q       <= resync;
      if (s1_load) begin
        s1_valid_q <= 1'b1;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end
      if (s2_load) begin
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Data registers: row buffer, column-pass result and the held output tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < TILE; r++) begin
        for (int c = 0; c < TILE; c++) begin
          row_q[r][c] <= '0;
          t_q[r][c]   <= '0;
          v_q[r][c]   <= '0;
        end
      end
    end else begin
      if (accept) begin
        for (int c = 0; c < TILE; c++) begin
          row_q[wr_idx][c] <= bus.in_row[c*WI +: WI];
        end
      end
      if (s1_load) begin
        for (int r = 0; r < TILE; r++) begin
          for (int c = 0; c < TILE; c++) begin
            t_q[r][c] <= tcol[c][r];
          end
        end
      end
      if (s2_load) begin
        v_q <= vconv;
      end
    end
  end

endmodule

// File: tb/tb_wino_input_transform.sv
// Testbench for wino_input_transform. Runs a lossless WO=10 instance and a
// WO=9 instance side by side on the same stimulus; the WO=9 expectations
// follow WINO_IN_SAT_EN.
module tb_wino_input_transform;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  wino_input_transform_if #(.WI(8), .WO(10)) ifa ();
  wino_input_transform_if #(.WI(8), .WO(9))  ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_first  = ifa.in_first;
  assign ifb.in_row    = ifa.in_row;
  assign ifb.out_ready = ifa.out_ready;

  wino_input_transform #(.WI(8), .WO(10)) dut (.clk(clk), .rst(rst), .bus(ifa));
  wino_input_transform #(.WI(8), .WO(9))  dut9 (.clk(clk), .rst(rst), .bus(ifb));

  localparam int BMT [4][4] = '{
    '{1, 0, -1, 0}, '{0, 1, 1, 0}, '{0, -1, 1, 0}, '{0, 1, 0, -1}
  };

  int checks = 0;
  int errors = 0;
  int partRows [4][4];
  int partCnt = 0;
  int txCount = 0;
  int rxCount = 0;
  logic [159:0] exp10Q [$];
  logic [143:0] exp9Q [$];
  logic [159:0] e10, prevV;
  logic [143:0] e9;
  logic stallPrev = 1'b0;

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [8:0] to9(input int v);
    int x;
    x = v;
`ifdef WINO_IN_SAT_EN
    if (x > 255) x = 255;
    if (x < -256) x = -256;
`endif
    return 9'(x);
  endfunction

  // Reference: V = B^T * d * B by plain matrix arithmetic on the buffered rows.
  task automatic pushExpected();
    int t [4][4];
    int v;
    logic [159:0] p10;
    logic [143:0] p9;
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < 4; c++) begin
        t[i][c] = 0;
        for (int k = 0; k < 4; k++) t[i][c] += BMT[i][k] * partRows[k][c];
      end
    for (int r = 0; r < 4; r++)
      for (int j = 0; j < 4; j++) begin
        v = 0;
        for (int k = 0; k < 4; k++) v += t[r][k] * BMT[j][k];
        p10[(4*r+j)*10 +: 10] = 10'(v);
        p9[(4*r+j)*9 +: 9] = to9(v);
      end
    exp10Q.push_back(p10);
    exp9Q.push_back(p9);
    txCount++;
  endtask

  // Offer one row, wait (bounded) for acceptance, then update the tile model.
  task automatic applyStimulus(input logic [31:0] row, input logic first);
    int n;
    logic expResync;
    n = 0;
    ifa.in_valid = 1'b1;
    ifa.in_row   = row;
    ifa.in_first = first;
    @(negedge clk);
    while (!ifa.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("row_accept_timeout", 160'(ifa.in_ready), 160'(1));
    @(posedge clk);
    #1;
    ifa.in_valid = 1'b0;
    ifa.in_first = 1'b0;
    if (n < 200) begin
      expResync = first && (partCnt != 0);
      if (expResync) partCnt = 0;
      for (int c = 0; c < 4; c++) partRows[partCnt][c] = int'($signed(row[c*8 +: 8]));
      partCnt++;
      if (partCnt == 4) begin
        pushExpected();
        partCnt = 0;
      end
      checkOutput("err_resync", 160'(ifa.err_resync), 160'(expResync));
    end
  endtask

  task automatic sendRandomTile();
    for (int r = 0; r < 4; r++) applyStimulus($urandom(), (r == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
  endtask

  // Called right after row 3 is accepted: output appears two cycles later.
  task automatic checkLatency(input string tag, input logic [9:0] v11, input logic [8:0] v11n);
    checkOutput({tag, "_lat0"}, 160'(ifa.out_valid), 160'(0));
    @(posedge clk); #1;
    checkOutput({tag, "_lat1"}, 160'(ifa.out_valid), 160'(0));
    @(posedge clk); #1;
    checkOutput({tag, "_lat2"}, 160'(ifa.out_valid), 160'(1));
    checkOutput({tag, "_v11"}, 160'(ifa.out_v[50 +: 10]), 160'(v11));
    checkOutput({tag, "_v11_wo9"}, 160'(ifb.out_v[45 +: 9]), 160'(v11n));
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (exp10Q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkOutput({tag, "_drain"}, 160'(exp10Q.size()), 160'(0));
  endtask

  // Output monitor: scoreboard pop on every transfer, hold check while stalled.
  always @(negedge clk) begin
    if (rst) begin
      stallPrev = 1'b0;
    end else begin
      if (stallPrev && ifa.out_valid) checkOutput("out_v_stable", ifa.out_v, prevV);
      stallPrev = ifa.out_valid && !ifa.out_ready;
      prevV = ifa.out_v;
      if (ifa.out_valid && ifa.out_ready) begin
        rxCount++;
        if (exp10Q.size() != 0) begin
          e10 = exp10Q.pop_front();
          e9 = exp9Q.pop_front();
          checkOutput("tile_v_wo10", ifa.out_v, e10);
          checkOutput("tile_v_wo9", 160'(ifb.out_v), 160'(e9));
        end
      end
    end
  end

  initial begin
    ifa.in_valid  = 1'b0;
    ifa.in_first  = 1'b0;
    ifa.in_row    = '0;
    ifa.out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_out_valid", 160'(ifa.out_valid), 160'(0));
    checkOutput("reset_in_ready", 160'(ifa.in_ready), 160'(1));
    checkOutput("reset_err", 160'(ifa.err_resync), 160'(0));

    $display("[TB] T1 all-ones tile");
    for (int r = 0; r < 4; r++) applyStimulus(32'h01010101, r == 0);
    checkLatency("t1", 10'd4, 9'd4);
    waitDrain("t1");

    $display("[TB] T2 delta tile");
    applyStimulus(32'h0, 1'b1);
    applyStimulus(32'h00000100, 1'b0);
    applyStimulus(32'h0, 1'b0);
    applyStimulus(32'h0, 1'b0);
    checkLatency("t2", 10'd1, 9'd1);
    waitDrain("t2");

    $display("[TB] T3 width corners");
    applyStimulus(32'h0, 1'b1);
    applyStimulus(32'h007f7f00, 1'b0);
    applyStimulus(32'h007f7f00, 1'b0);
    applyStimulus(32'h0, 1'b0);
`ifdef WINO_IN_SAT_EN
    checkLatency("t3_pos", 10'd508, 9'd255);
`else
    checkLatency("t3_pos", 10'd508, 9'h1fc);
`endif
    waitDrain("t3_pos");
    for (int r = 0; r < 4; r++) applyStimulus(32'h80808080, r == 0);
`ifdef WINO_IN_SAT_EN
    checkLatency("t3_neg", 10'h200, 9'h100);
`else
    checkLatency("t3_neg", 10'h200, 9'h000);
`endif
    waitDrain("t3_neg");

    $display("[TB] random tiles back to back");
    for (int k = 0; k < 6; k++) sendRandomTile();
    waitDrain("rand");

    $display("[TB] T4 stall with 5 tiles");
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) sendRandomTile();
    checkOutput("t4_full_in_ready", 160'(ifa.in_ready), 160'(0));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("t4_still_blocked", 160'(ifa.in_ready), 160'(0));
    checkOutput("t4_out_valid", 160'(ifa.out_valid), 160'(1));
    ifa.out_ready = 1'b1;
    for (int k = 0; k < 2; k++) sendRandomTile();
    waitDrain("t4");

    $display("[TB] T5 resync");
    applyStimulus($urandom(), 1'b1);
    applyStimulus($urandom(), 1'b0);
    applyStimulus($urandom(), 1'b1);
    for (int r = 0; r < 3; r++) applyStimulus($urandom(), 1'b0);
    waitDrain("t5");

    $display("[TB] T6 reset mid-pipe");
    ifa.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) sendRandomTile();
    applyStimulus($urandom(), 1'b1);
    applyStimulus($urandom(), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    txCount -= exp10Q.size();
    exp10Q.delete();
    exp9Q.delete();
    partCnt = 0;
    checkOutput("t6_out_valid", 160'(ifa.out_valid), 160'(0));
    checkOutput("t6_in_ready", 160'(ifa.in_ready), 160'(1));
    ifa.out_ready = 1'b1;
    sendRandomTile();
    waitDrain("t6");

    repeat (3) @(posedge clk);
    #1;
    checkOutput("tile_count", 160'(rxCount), 160'(txCount));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
